// File: rtl/aos_softreg_read_guard.sv
// Read guard between the host SoftReg port and the per-app SoftReg router.
// Keeps one outstanding read per app and answers the host with app data or ERR_DATA.
module aos_softreg_read_guard #(
    parameter int unsigned NUM_APPS       = 4,
    parameter int unsigned SEL_LSB        = 13,
    parameter int unsigned SEL_BITS       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [63:0] ERR_DATA       = 64'hDEAD_DEAD_DEAD_DEAD,
    parameter int unsigned ERR_CNT_BITS   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_APPS-1:0]     app_enable,
    input  logic                    host_req_valid,
    input  logic                    host_req_is_write,
    input  logic [31:0]             host_req_addr,
    input  logic [63:0]             host_req_data,
    output logic                    fwd_req_valid,
    output logic                    fwd_req_is_write,
    output logic [31:0]             fwd_req_addr,
    output logic [63:0]             fwd_req_data,
    input  logic [NUM_APPS-1:0]     app_resp_valid,
    input  logic [NUM_APPS*64-1:0]  app_resp_data,
    output logic                    host_resp_valid,
    output logic [63:0]             host_resp_data,
    output logic [NUM_APPS-1:0]     app_busy,
    output logic [15:0]             timeout_count,
    output logic [15:0]             drop_count
);

    localparam int unsigned IDX_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EVT_W = 4;
    localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RDY  = 2'd2
    } app_state_e;

    app_state_e              state_q [NUM_APPS];
    app_state_e              state_d [NUM_APPS];
    logic [TMR_W-1:0]        timer_q [NUM_APPS];
    logic [TMR_W-1:0]        timer_d [NUM_APPS];
    logic [63:0]             slot_q  [NUM_APPS];
    logic [63:0]             slot_d  [NUM_APPS];
    logic [ERR_CNT_BITS-1:0] err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic                    fwd_valid_q, fwd_valid_d;
    logic                    fwd_write_q, fwd_write_d;
    logic [31:0]             fwd_addr_q, fwd_addr_d;
    logic [63:0]             fwd_data_q, fwd_data_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [63:0]             resp_data_q, resp_data_d;
    logic [NUM_APPS-1:0]     busy_q, busy_d;
    logic [15:0]             tmo_cnt_q, tmo_cnt_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;

    logic [SEL_BITS-1:0]     sel;
    logic                    sel_ok;
    logic [IDX_W-1:0]        sel_idx;
    logic                    rd_fwd, wr_drop, err_inc, err_dec;
    logic                    grant_any;
    logic [IDX_W-1:0]        grant_idx, rot;
    logic [EVT_W-1:0]        drop_evts, tmo_evts;
    logic [16:0]             drop_sum, tmo_sum;

    // Next-state for request decode, arbitration, per-app slots and counters
    always_comb begin
        sel         = host_req_addr[SEL_LSB +: SEL_BITS];
        sel_ok      = 1'b0;
        sel_idx     = '0;
        grant_any   = 1'b0;
        grant_idx   = '0;
        rot         = '0;
        drop_evts   = '0;
        tmo_evts    = '0;
        err_cnt_d   = err_cnt_q;
        rr_d        = rr_q;
        fwd_valid_d = 1'b0;
        fwd_write_d = fwd_write_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        resp_valid_d = 1'b0;
        resp_data_d = resp_data_q;
        busy_d      = '0;

        // Full select field is compared, so out-of-range indices never match
        for (int i = 0; i < NUM_APPS; i++) begin
            if (sel == SEL_BITS'(i)) begin
                sel_ok  = app_enable[i];
                sel_idx = IDX_W'(i);
            end
        end

        rd_fwd  = host_req_valid && !host_req_is_write && sel_ok && (state_q[sel_idx] == ST_IDLE);
        wr_drop = host_req_valid && host_req_is_write && !sel_ok;
        err_inc = host_req_valid && !host_req_is_write && !rd_fwd;
        err_dec = (err_cnt_q != '0);

        if ((host_req_valid && host_req_is_write && sel_ok) || rd_fwd) begin
            fwd_valid_d = 1'b1;
            fwd_write_d = host_req_is_write;
            fwd_addr_d  = host_req_addr;
            fwd_data_d  = host_req_data;
        end
        if (wr_drop) begin
            drop_evts = drop_evts + EVT_W'(1);
        end

        // Round-robin search starting after the last granted slot
        for (int unsigned k = 1; k <= NUM_APPS; k++) begin
            rot = IDX_W'((32'(rr_q) + k) % NUM_APPS);
            if (!grant_any && state_q[rot] == ST_RDY) begin
                grant_any = 1'b1;
                grant_idx = rot;
            end
        end

        if (err_dec) begin
            resp_valid_d = 1'b1;
            resp_data_d  = ERR_DATA;
        end else if (grant_any) begin
            resp_valid_d = 1'b1;
            resp_data_d  = slot_q[grant_idx];
            rr_d         = grant_idx;
        end

        if (err_inc && !err_dec) begin
            if (err_cnt_q == ERR_MAX) begin
                drop_evts = drop_evts + EVT_W'(1);
            end else begin
                err_cnt_d = err_cnt_q + ERR_CNT_BITS'(1);
            end
        end else if (!err_inc && err_dec) begin
            err_cnt_d = err_cnt_q - ERR_CNT_BITS'(1);
        end

        for (int i = 0; i < NUM_APPS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            slot_d[i]  = slot_q[i];
            unique case (state_q[i])
                ST_IDLE: begin
                    if (rd_fwd && sel_idx == IDX_W'(i)) begin
                        state_d[i] = ST_WAIT;
                        timer_d[i] = TMR_W'(TIMEOUT_CYCLES);
                    end
                end
                ST_WAIT: begin
                    if (app_resp_valid[i]) begin
                        state_d[i] = ST_RDY;
                        slot_d[i]  = app_resp_data[64*i +: 64];
                    end else if (!app_enable[i]) begin
                        state_d[i] = ST_RDY;
                        slot_d[i]  = ERR_DATA;
                    end else if (timer_q[i] == TMR_W'(1)) begin
                        state_d[i] = ST_RDY;
                        slot_d[i]  = ERR_DATA;
                        tmo_evts   = tmo_evts + EVT_W'(1);
                    end else begin
                        timer_d[i] = timer_q[i] - TMR_W'(1);
                    end
                end
                ST_RDY: begin
                    if (!err_dec && grant_any && grant_idx == IDX_W'(i)) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            if (app_resp_valid[i] && state_q[i] != ST_WAIT) begin
                drop_evts = drop_evts + EVT_W'(1);
            end
            busy_d[i] = (state_d[i] != ST_IDLE);
        end

        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_evts);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        tmo_sum    = {1'b0, tmo_cnt_q} + 17'(tmo_evts);
        tmo_cnt_d  = tmo_sum[16] ? 16'hFFFF : tmo_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_APPS; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
                slot_q[i]  <= '0;
            end
            err_cnt_q    <= '0;
            rr_q         <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_write_q  <= 1'b0;
            fwd_addr_q   <= '0;
            fwd_data_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            busy_q       <= '0;
            tmo_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_APPS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                slot_q[i]  <= slot_d[i];
            end
            err_cnt_q    <= err_cnt_d;
            rr_q         <= rr_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_write_q  <= fwd_write_d;
            fwd_addr_q   <= fwd_addr_d;
            fwd_data_q   <= fwd_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            busy_q       <= busy_d;
            tmo_cnt_q    <= tmo_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign fwd_req_valid    = fwd_valid_q;
    assign fwd_req_is_write = fwd_write_q;
    assign fwd_req_addr     = fwd_addr_q;
    assign fwd_req_data     = fwd_data_q;
    assign host_resp_valid  = resp_valid_q;
    assign host_resp_data   = resp_data_q;
    assign app_busy         = busy_q;
    assign timeout_count    = tmo_cnt_q;
    assign drop_count       = drop_cnt_q;

endmodule
